cpu_register_file: RTL

- General-purpose register file directly downstream of the instruction decoder in the SLURM32 pipeline.
- Consumes the decoder's regA_sel/regB_sel selects and returns operand A/B one cycle later to the execute stage.
- Accepts one write-back per cycle from the end of the pipeline.
- After reset, runs a sequential clear of all entries, because the storage array is BRAM-inferable and has no reset.

---
 rtl/cpu_register_file_pkg.sv | 12 +
 rtl/cpu_register_file_if.sv | 28 ++
 rtl/cpu_regfile_bank.sv | 25 ++
 rtl/cpu_register_file.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpu_register_file_pkg.sv
// Shared definitions for the SLURM32 general-purpose register file.
// FSM encodings and the hard-wired zero register index.
package cpu_register_file_pkg;

  typedef enum logic {
    REGFILE_STATE_INIT = 1'b0,
    REGFILE_STATE_RUN  = 1'b1
  } regfile_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/cpu_register_file_if.sv
// Decoder/write-back side bus of the register file.
// The pipeline drives the master side; the register file is the slave.
interface cpu_register_file_if #(
  parameter int BITS          = 32,
  parameter int REGISTER_BITS = 8
);

  logic [REGISTER_BITS-1:0] rega_sel;
  logic [REGISTER_BITS-1:0] regb_sel;
  logic                     stall;
  logic                     wr_en;
  logic [REGISTER_BITS-1:0] wr_sel;
  logic [BITS-1:0]          wr_data;
  logic [BITS-1:0]          rega_out;
  logic [BITS-1:0]          regb_out;
  logic                     init_busy;

  modport master (
    output rega_sel, regb_sel, stall, wr_en, wr_sel, wr_data,
    input  rega_out, regb_out, init_busy
  );

  modport slave (
    input  rega_sel, regb_sel, stall, wr_en, wr_sel, wr_data,
    output rega_out, regb_out, init_busy
  );

endinterface

// File: rtl/cpu_regfile_bank.sv
// One copy of the register storage: a synchronous write port and a registered
// read port with no reset, so the array maps onto block RAM.
module cpu_regfile_bank #(
  parameter int BITS          = 32,
  parameter int REGISTER_BITS = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [REGISTER_BITS-1:0] waddr,
  input  logic [BITS-1:0]          wdata,
  input  logic [REGISTER_BITS-1:0] raddr,
  output logic [BITS-1:0]          rdata
);

  logic [BITS-1:0] mem [2**REGISTER_BITS];

  // Read-before-write; the top level supplies the bypassed value on collisions.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_register_file.sv
// SLURM32 register file: two registered read ports, one write-back port,
// write-first bypass, r0 hard-wired to zero and a sequential clear after reset.
module cpu_register_file
  import cpu_register_file_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int REGISTER_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  cpu_register_file_if.slave  bus
);

  localparam int                       DEPTH      = 2**REGISTER_BITS;
  localparam logic [REGISTER_BITS-1:0] LAST_ENTRY = REGISTER_BITS'(DEPTH - 1);
  localparam logic [REGISTER_BITS-1:0] ZERO_SEL   = REGISTER_BITS'(REG_ZERO);

  regfile_state_e           state_reg, state_next;
  logic [REGISTER_BITS-1:0] init_ptr_reg, init_ptr_next;
  logic                     in_init;
  logic                     wb_valid;
  logic                     bank_we;
  logic [REGISTER_BITS-1:0] bank_waddr;
  logic [BITS-1:0]          bank_wdata;
  logic [BITS-1:0]          wb_data_reg;
  logic [REGISTER_BITS-1:0] port_sel [2];
  logic [BITS-1:0]          port_out [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= REGFILE_STATE_INIT;
      init_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_ptr_reg <= init_ptr_next;
    end
  end

  // The pointer holds on the last entry instead of wrapping back to zero.
  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    case (state_reg)
      REGFILE_STATE_INIT: begin
        if (init_ptr_reg == LAST_ENTRY) begin
          state_next = REGFILE_STATE_RUN;
        end else begin
          init_ptr_next = init_ptr_reg + 1'b1;
        end
      end
      REGFILE_STATE_RUN: begin
        state_next = REGFILE_STATE_RUN;
      end
      default: begin
        state_next    = REGFILE_STATE_INIT;
        init_ptr_next = '0;
      end
    endcase
  end

  assign in_init       = (state_reg == REGFILE_STATE_INIT);
  assign bus.init_busy = in_init;

  assign wb_valid   = !in_init && bus.wr_en && (bus.wr_sel != ZERO_SEL);
  assign bank_we    = in_init || wb_valid;
  assign bank_waddr = in_init ? init_ptr_reg : bus.wr_sel;
  assign bank_wdata = in_init ? '0 : bus.wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_reg <= '0;
    end else begin
      wb_data_reg <= bus.wr_data;
    end
  end

  assign port_sel[0] = bus.rega_sel;
  assign port_sel[1] = bus.regb_sel;

  // Each read port keeps its own held select and bank copy; zero/bypass
  // decisions are registered alongside the RAM read so the output mux is flat.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [REGISTER_BITS-1:0] held_reg;
    logic [REGISTER_BITS-1:0] eff_sel;
    logic                     force_zero_reg;
    logic                     bypass_reg;
    logic [BITS-1:0]          bank_rdata;

    assign eff_sel = bus.stall ? held_reg : port_sel[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        held_reg       <= '0;
        force_zero_reg <= 1'b1;
        bypass_reg     <= 1'b0;
      end else begin
        if (!bus.stall) begin
          held_reg <= port_sel[gi];
        end
        force_zero_reg <= in_init || (eff_sel == ZERO_SEL);
        bypass_reg     <= wb_valid && (bus.wr_sel == eff_sel);
      end
    end

    cpu_regfile_bank #(
      .BITS          (BITS),
      .REGISTER_BITS (REGISTER_BITS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (eff_sel),
      .rdata (bank_rdata)
    );

    assign port_out[gi] = force_zero_reg ? '0 :
                          bypass_reg     ? wb_data_reg : bank_rdata;
  end

  assign bus.rega_out = port_out[0];
  assign bus.regb_out = port_out[1];

endmodule
